// File: rtl/dds_sweep_ctrl.sv
// DDS tuning-word sweep sequencer: passes the static word through when idle,
// otherwise steps it linearly between shadowed start/stop values with a dwell per step.
module dds_sweep_ctrl #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] adder_in,
  input  logic [AW-1:0] cfg_start,
  input  logic [AW-1:0] cfg_stop,
  input  logic [AW-1:0] cfg_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [1:0]    cfg_mode,
  input  logic          cfg_load,
  input  logic          go,
  input  logic          abort,
  output logic [AW-1:0] adder_out,
  output logic          busy,
  output logic          marker,
  output logic          done,
  output logic          cfg_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2,
    HOLD     = 2'd3
  } state_e;

  localparam logic [1:0] MODE_REPEAT = 2'd1;
  localparam logic [1:0] MODE_UPDOWN = 2'd2;

  state_e        state_q, state_d;
  logic [AW-1:0] out_q, out_d;
  logic          busy_q, busy_d;
  logic          marker_q, marker_d;
  logic          done_q, done_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] sh_start_q, sh_start_d;
  logic [AW-1:0] sh_stop_q, sh_stop_d;
  logic [AW-1:0] sh_step_q, sh_step_d;
  logic [DW-1:0] sh_dwell_q, sh_dwell_d;
  logic [1:0]    sh_mode_q, sh_mode_d;

  logic [DW-1:0] reload;
  logic [AW:0]   up_sum;
  logic [AW:0]   dn_dif;
  logic          up_sat;
  logic          dn_sat;

  assign adder_out = out_q;
  assign busy      = busy_q;
  assign marker    = marker_q;
  assign done      = done_q;
  assign cfg_err   = (sh_start_q > sh_stop_q) || (sh_step_q == '0);

  // Step arithmetic is one bit wider so carry/borrow saturate instead of wrapping.
  assign reload = (sh_dwell_q == '0) ? '0 : sh_dwell_q - DW'(1);
  assign up_sum = {1'b0, out_q} + {1'b0, sh_step_q};
  assign dn_dif = {1'b0, out_q} - {1'b0, sh_step_q};
  assign up_sat = (up_sum >= {1'b0, sh_stop_q});
  assign dn_sat = dn_dif[AW] || (dn_dif[AW-1:0] <= sh_start_q);

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    marker_d   = 1'b0;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    sh_start_d = sh_start_q;
    sh_stop_d  = sh_stop_q;
    sh_step_d  = sh_step_q;
    sh_dwell_d = sh_dwell_q;
    sh_mode_d  = sh_mode_q;

    if (abort) begin
      state_d = IDLE;
      out_d   = adder_in;
    end else if (go && !cfg_err) begin
      state_d  = RUN_UP;
      out_d    = sh_start_q;
      cnt_d    = reload;
      marker_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: out_d = adder_in;
        RUN_UP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DW'(1);
          end else begin
            cnt_d = reload;
            if (out_q == sh_stop_q) begin
              case (sh_mode_q)
                MODE_REPEAT: begin
                  out_d    = sh_start_q;
                  marker_d = 1'b1;
                end
                MODE_UPDOWN: begin
                  // Turnaround takes the first decrement now; degenerate span re-marks start.
                  state_d  = RUN_DOWN;
                  out_d    = dn_sat ? sh_start_q : dn_dif[AW-1:0];
                  marker_d = (sh_start_q == sh_stop_q);
                end
                default: begin
                  state_d = HOLD;
                  done_d  = 1'b1;
                end
              endcase
            end else begin
              out_d = up_sat ? sh_stop_q : up_sum[AW-1:0];
            end
          end
        end
        RUN_DOWN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DW'(1);
          end else begin
            cnt_d = reload;
            if (out_q == sh_start_q) begin
              state_d  = RUN_UP;
              marker_d = 1'b1;
            end else begin
              out_d = dn_sat ? sh_start_q : dn_dif[AW-1:0];
            end
          end
        end
        HOLD: ;
        default: state_d = IDLE;
      endcase
    end

    if (cfg_load && ((state_q == IDLE) || (state_q == HOLD))) begin
      sh_start_d = cfg_start;
      sh_stop_d  = cfg_stop;
      sh_step_d  = cfg_step;
      sh_dwell_d = cfg_dwell;
      sh_mode_d  = cfg_mode;
    end

    busy_d = (state_d == RUN_UP) || (state_d == RUN_DOWN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      out_q      <= '0;
      busy_q     <= 1'b0;
      marker_q   <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      sh_start_q <= '0;
      sh_stop_q  <= '0;
      sh_step_q  <= '0;
      sh_dwell_q <= '0;
      sh_mode_q  <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      marker_q   <= marker_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      sh_start_q <= sh_start_d;
      sh_stop_q  <= sh_stop_d;
      sh_step_q  <= sh_step_d;
      sh_dwell_q <= sh_dwell_d;
      sh_mode_q  <= sh_mode_d;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed sweeps plus random traffic against a plateau-level model.
module tb_dds_sweep_ctrl;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 24;
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_HOLD = 2;

  logic          clk;
  logic          rst;
  logic [AW-1:0] adder_in;
  logic [AW-1:0] cfg_start, cfg_stop, cfg_step;
  logic [DW-1:0] cfg_dwell;
  logic [1:0]    cfg_mode;
  logic          cfg_load, go, abort;
  logic [AW-1:0] adder_out;
  logic          busy, marker, done, cfg_err;

  int checks = 0;
  int errors = 0;

  // model state
  longint m_out, m_left;
  bit     m_busy, m_marker, m_done, m_up;
  int     m_phase;
  longint m_start, m_stop, m_step, m_dwell;
  int     m_mode;

  int n_done, n_marker;

  dds_sweep_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .adder_in(adder_in),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_load(cfg_load),
    .go(go), .abort(abort), .adder_out(adder_out), .busy(busy),
    .marker(marker), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  function automatic longint lmax(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    m_out = 0; m_left = 0; m_busy = 0; m_marker = 0; m_done = 0; m_up = 1;
    m_phase = P_IDLE;
    m_start = 0; m_stop = 0; m_step = 0; m_dwell = 0; m_mode = 0;
  endtask

  // Move to the next plateau of the sweep.
  task automatic model_advance();
    if (m_up) begin
      if (m_out == m_stop) begin
        if (m_mode == 1) begin
          m_out = m_start; m_marker = 1;
        end else if (m_mode == 2) begin
          m_up = 0;
          m_out = lmax(m_out - m_step, m_start);
          m_marker = (m_start == m_stop);
        end else begin
          m_phase = P_HOLD; m_done = 1;
        end
      end else begin
        m_out = lmin(m_out + m_step, m_stop);
      end
    end else begin
      if (m_out == m_start) begin
        m_up = 1; m_marker = 1;
      end else begin
        m_out = lmax(m_out - m_step, m_start);
      end
    end
  endtask

  task automatic model_step();
    longint per;
    bit     err;
    int     ph0;
    per = (m_dwell == 0) ? 1 : m_dwell;
    err = (m_start > m_stop) || (m_step == 0);
    ph0 = m_phase;
    m_marker = 0; m_done = 0;
    if (abort) begin
      m_phase = P_IDLE; m_out = longint'(adder_in);
    end else if (go && !err) begin
      m_phase = P_RUN; m_up = 1; m_out = m_start; m_left = per; m_marker = 1;
    end else if (m_phase == P_IDLE) begin
      m_out = longint'(adder_in);
    end else if (m_phase == P_RUN) begin
      m_left--;
      if (m_left == 0) begin
        m_left = per;
        model_advance();
      end
    end
    if (cfg_load && (ph0 == P_IDLE || ph0 == P_HOLD)) begin
      m_start = longint'(cfg_start); m_stop = longint'(cfg_stop);
      m_step = longint'(cfg_step); m_dwell = longint'(cfg_dwell);
      m_mode = int'(cfg_mode);
    end
    m_busy = (m_phase == P_RUN);
  endtask

  // Advance one clock with the current inputs, then compare all outputs.
  task automatic step_clk();
    bit exp_err;
    model_step();
    @(negedge clk);
    exp_err = (m_start > m_stop) || (m_step == 0);
    chk("adder_out", 64'(adder_out), 64'(m_out));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("marker", 64'(marker), 64'(m_marker));
    chk("done", 64'(done), 64'(m_done));
    chk("cfg_err", 64'(cfg_err), 64'(exp_err));
    if (done) n_done++;
    if (marker) n_marker++;
  endtask

  task automatic load_cfg(input logic [AW-1:0] s, input logic [AW-1:0] e,
                          input logic [AW-1:0] st, input logic [DW-1:0] dw,
                          input logic [1:0] md);
    cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = dw; cfg_mode = md;
    cfg_load = 1'b1;
    step_clk();
    cfg_load = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    step_clk();
    go = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
  endtask

  task automatic rand_cfg();
    longint s, e;
    if ($urandom_range(0, 3) == 0) begin
      s = longint'(32'hFFFF_FF00) + longint'($urandom_range(0, 255));
      e = lmin(s + longint'($urandom_range(0, 255)), longint'(32'hFFFF_FFFF));
      cfg_step = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(1, 300)) : AW'($urandom);
    end else begin
      s = longint'($urandom_range(0, 200));
      e = ($urandom_range(0, 7) == 0) ? longint'($urandom_range(0, 200))
                                      : s + longint'($urandom_range(0, 100));
      cfg_step = AW'($urandom_range(0, 40));
    end
    cfg_start = AW'(s);
    cfg_stop  = AW'(e);
    cfg_dwell = DW'($urandom_range(0, 4));
    cfg_mode  = 2'($urandom_range(0, 3));
  endtask

  initial begin
    int r;
    rst = 1'b0;
    adder_in = 32'h0100_0000;
    cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = '0;
    cfg_load = 1'b0; go = 1'b0; abort = 1'b0;
    n_done = 0; n_marker = 0;
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_adder_out", 64'(adder_out), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_cfg_err", 64'(cfg_err), 64'h1);
    rst = 1'b1;
    step_clk();
    chk("pass_first", 64'(adder_out), 64'h0100_0000);

    // single sweep 100..130 step 10 dwell 3
    load_cfg(32'd100, 32'd130, 32'd10, 24'd3, 2'd0);
    n_done = 0; n_marker = 0;
    pulse_go();
    repeat (15) step_clk();
    chk("single_done_cnt", 64'(n_done), 64'd1);
    chk("single_marker_cnt", 64'(n_marker), 64'd1);
    chk("single_hold_val", 64'(adder_out), 64'd130);
    chk("single_hold_busy", 64'(busy), 64'd0);

    // repeat sweep near the top of the range, dwell 0
    load_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd0, 2'd1);
    n_marker = 0;
    pulse_go();
    repeat (7) step_clk();
    chk("repeat_marker_cnt", 64'(n_marker), 64'd4);
    pulse_abort();

    // up-down 10..25 step 10 dwell 1
    load_cfg(32'd10, 32'd25, 32'd10, 24'd1, 2'd2);
    n_marker = 0;
    pulse_go();
    repeat (13) step_clk();
    chk("updown_marker_cnt", 64'(n_marker), 64'd3);
    pulse_abort();

    // invalid configs
    load_cfg(32'd50, 32'd40, 32'd10, 24'd1, 2'd0);
    chk("err_start_gt_stop", 64'(cfg_err), 64'd1);
    pulse_go();
    chk("err_go_ignored", 64'(busy), 64'd0);
    load_cfg(32'd0, 32'd10, 32'd0, 24'd1, 2'd0);
    chk("err_zero_step", 64'(cfg_err), 64'd1);

    // go+abort together, then load while busy
    load_cfg(32'd100, 32'd200, 32'd5, 24'd2, 2'd0);
    pulse_go();
    repeat (4) step_clk();
    go = 1'b1; abort = 1'b1;
    step_clk();
    go = 1'b0; abort = 1'b0;
    chk("abort_wins_busy", 64'(busy), 64'd0);
    chk("abort_wins_marker", 64'(marker), 64'd0);
    pulse_go();
    load_cfg(32'd0, 32'd1000, 32'd1, 24'd1, 2'd1);
    pulse_abort();
    pulse_go();
    chk("busy_load_ignored", 64'(adder_out), 64'd100);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      adder_in = $urandom;
      r = $urandom_range(0, 99);
      go = (r < 3) || (r == 7);
      abort = (r == 3) || (r == 7);
      cfg_load = (r >= 4) && (r < 7);
      if (cfg_load) rand_cfg();
      step_clk();
      go = 1'b0; abort = 1'b0; cfg_load = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Sequences the phase-accumulator tuning word of the DDS signal generator. It sits between the RS-232 control block's adder output and the accumulator.
- When idle it passes the static tuning word through.
- When running it steps the tuning word linearly from a start value to a stop value, holding each step for a programmable dwell time.
- It emits a sweep-start marker for scope triggering and a completion pulse.

Parameters:
- AW, 32, tuning-word width (matches accumulator adder width)
- DW, 24, dwell counter width

Ports:
- clk  input  1  system clock (200 MHz DDS clock)
- rst  input  1  asynchronous, active-low reset (0 = reset)
- adder_in  input  AW  static tuning word from the control block, used when not sweeping
- cfg_start  input  AW  sweep start tuning word
- cfg_stop  input  AW  sweep stop tuning word
- cfg_step  input  AW  increment per step
- cfg_dwell  input  DW  clocks per step; 0 is treated as 1
- cfg_mode  input  2  0 = single, 1 = repeat (sawtooth), 2 = up-down (triangle), 3 = reserved (treated as single)
- cfg_load  input  1  one-clock pulse: latch all cfg_* into shadow registers
- go  input  1  one-clock pulse: start or restart the sweep
- abort  input  1  one-clock pulse: stop the sweep and return to passthrough
- adder_out  output  AW  tuning word to the accumulator, registered
- busy  output  1  high in RUN_UP/RUN_DOWN
- marker  output  1  one-clock pulse each time adder_out is (re)loaded with start
- done  output  1  one-clock pulse when a single sweep completes
- cfg_err  output  1  shadow config invalid (start > stop, or step == 0)

Behaviour:
- Reset (rst = 0, async):
  - state = IDLE.
  - adder_out, shadows, dwell counter = 0.
  - busy, marker, done = 0; cfg_err = 1 (zero step).
- States: IDLE, RUN_UP, RUN_DOWN, HOLD.
- Shadow registers:
  - Updated by cfg_load only in IDLE or HOLD; ignored while busy.
  - cfg_err is recomputed combinationally from the shadows.
- IDLE: adder_out <= adder_in every clock (1-cycle latency).
- go accepted (any state) with cfg_err = 0:
  - Next clock: adder_out = start, state = RUN_UP.
  - dwell counter = max(dwell,1) - 1; marker = 1 for that clock.
- go with cfg_err = 1: ignored, no state change.
- abort: next clock state = IDLE, busy = 0, passthrough resumes. abort wins over a simultaneous go.
- Dwell: the counter decrements each clock in RUN_UP/RUN_DOWN. At 0 the step is taken and the counter reloads.
- RUN_UP step:
  - next = adder_out + step, computed in AW+1 bits.
  - If current == stop: mode-dependent end action (below).
  - Else if next ≥ stop or carry out: adder_out = stop.
  - Else: adder_out = next.
- End action at stop (after its full dwell):
  - single → HOLD, done = 1 for one clock.
  - repeat → adder_out = start, marker = 1, stay in RUN_UP.
  - up-down → RUN_DOWN, first decrement taken immediately.
- RUN_DOWN step:
  - next = adder_out − step, computed in AW+1 bits.
  - If current == start: state = RUN_UP, marker = 1, adder_out unchanged (start dwelled once).
  - Else if borrow or next ≤ start: adder_out = start.
  - Else: adder_out = next.
- HOLD: adder_out stays at stop, busy = 0. go restarts the sweep; abort → IDLE.
- start == stop: each dwell period counts as one step.
  - single: done after one dwell.
  - repeat: marker every dwell.
  - up-down: marker every dwell, alternating states.
- busy is registered and asserted in the same clock as adder_out = start.

Test Plan:
1. Reset, then adder_in = 0x01000000 → adder_out = 0 during reset, 0x01000000 one clock after release; busy = 0; cfg_err = 1.
2. Single mode, start = 100, stop = 130, step = 10, dwell = 3, go → adder_out sequence 100, 110, 120, 130, each held 3 clocks; done pulses once; state HOLD; adder_out stays 130; marker pulses only at start.
3. Repeat mode, start = 0xFFFFFFF0, stop = 0xFFFFFFFF, step = 0x20, dwell = 0 → values 0xFFFFFFF0, 0xFFFFFFFF (saturated, no wrap), then 0xFFFFFFF0 with marker; 1 clock per value.
4. Up-down mode, start = 10, stop = 25, step = 10, dwell = 1 → 10, 20, 25, 15, 10 (saturated), then 20, 25, …; marker at each return to start.
5. start = 50, stop = 40, cfg_load, go → cfg_err = 1, go ignored, passthrough continues. cfg_load with step = 0 → cfg_err = 1.
6. go and abort in the same clock mid-sweep → IDLE next clock, adder_out = adder_in, no marker. cfg_load while busy → shadows unchanged, verified by a later go using the old values.
